// File: rtl/mem_port_arbiter.sv
// Arbitrates one Wishbone-style single-port memory between the fetch and data ports.
// The data port wins ties, and ports alternate on back-to-back traffic.
module mem_port_arbiter #(
  parameter int unsigned Timeout = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        err_o,
  output logic        stallreq_o,
  input  logic        flush_i,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);
  localparam int unsigned CntW = $clog2(Timeout + 1);

  typedef enum logic [1:0] {StIdle, StIbus, StDbus, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stb_q, stb_d, we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic            if_ack_q, if_ack_d, dm_ack_q, dm_ack_d, err_q, err_d;
  logic [31:0]     if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic            if_elig, dm_elig, timeout, grant_if, grant_dm;

  // A request still high in its own ack cycle is the old one, not a new one.
  assign if_elig = if_req_i & ~if_ack_q;
  assign dm_elig = dm_req_i & ~dm_ack_q;
  assign timeout = (cnt_q == CntW'(Timeout - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stb_d      = stb_q;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dm_elig) grant_dm = 1'b1;
        else if (if_elig) grant_if = 1'b1;
      end
      StIbus: begin
        if (mem_ack_i) begin
          if (flush_i) begin
            state_d = StIdle;
            stb_d   = 1'b0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata_i;
            if (dm_elig) begin
              grant_dm = 1'b1;
            end else begin
              state_d = StIdle;
              stb_d   = 1'b0;
            end
          end
        end else if (timeout) begin
          state_d = StIdle;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          if (!flush_i) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (flush_i) state_d = StDrain;
        end
      end
      StDbus: begin
        if (mem_ack_i) begin
          dm_ack_d   = 1'b1;
          dm_rdata_d = mem_rdata_i;
          if (if_elig) begin
            grant_if = 1'b1;
          end else begin
            state_d = StIdle;
            stb_d   = 1'b0;
          end
        end else if (timeout) begin
          state_d    = StIdle;
          stb_d      = 1'b0;
          err_d      = 1'b1;
          dm_ack_d   = 1'b1;
          dm_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        if (mem_ack_i) begin
          state_d = StIdle;
          stb_d   = 1'b0;
        end else if (timeout) begin
          state_d = StIdle;
          stb_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        stb_d   = 1'b0;
      end
    endcase
    if (grant_dm) begin
      state_d = StDbus;
      stb_d   = 1'b1;
      cnt_d   = '0;
      we_d    = dm_we_i;
      sel_d   = dm_sel_i;
      addr_d  = dm_addr_i;
      wdata_d = dm_wdata_i;
    end else if (grant_if) begin
      state_d = StIbus;
      stb_d   = 1'b1;
      cnt_d   = '0;
      we_d    = 1'b0;
      sel_d   = 4'hF;
      addr_d  = if_addr_i;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_ack_o    = dm_ack_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign err_o       = err_q;
  assign mem_cyc_o   = stb_q;
  assign mem_stb_o   = stb_q;
  assign mem_we_o    = we_q;
  assign mem_sel_o   = sel_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign stallreq_o  = (dm_req_i & ~dm_ack_q) | (if_req_i & ~if_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: wait-state memory model, per-port expected-ack queues,
// a table of single accesses and hand-written multi-cycle sequences.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0, flush_i = 1'b0;
  logic [31:0] if_addr_i = '0, dm_addr_i = '0, dm_wdata_i = '0;
  logic [3:0]  dm_sel_i = '0;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        if_ack_o, dm_ack_o, err_o, stallreq_o, mem_cyc_o, mem_stb_o, mem_we_o, mem_ack_i;
  logic [3:0]  mem_sel_o;

  int errors = 0;
  int checks = 0;
  int wait_states = 0;
  bit mem_noack = 1'b0;
  int stb_cnt = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [3:0]  wr_sel = '0;

  typedef struct { logic [31:0] data; logic err; } exp_t;
  exp_t if_q[$];
  exp_t dm_q[$];

  typedef struct {
    logic dm; logic we; logic [3:0] sel; logic [31:0] addr; logic [31:0] wdata;
    int waits; int exp_lat;
  } vec_t;
  vec_t vecs[7];

  logic t2_stb[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic t2_dack[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic t2_iack[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic t2_stl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic t5_stb[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic t5_iack[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .err_o(err_o), .stallreq_o(stallreq_o), .flush_i(flush_i),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0FF_EE00;
  endfunction

  // Memory acks once stb has been high for wait_states extra cycles.
  assign mem_rdata_i = mem_word(mem_addr_o);
  assign mem_ack_i   = mem_stb_o && !mem_noack && (stb_cnt == wait_states);

  always @(posedge clk) begin
    if (!mem_stb_o || mem_ack_i) stb_cnt <= 0;
    else stb_cnt <= stb_cnt + 1;
    if (mem_ack_i && mem_we_o) begin
      wr_addr <= mem_addr_o;
      wr_data <= mem_wdata_o;
      wr_sel  <= mem_sel_o;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if_ack_o) begin
      if (if_q.size() == 0) check("if_ack_unexpected", {31'b0, if_ack_o}, 32'd0);
      else begin
        e = if_q.pop_front();
        check("if_rdata", if_rdata_o, e.data);
        check("if_err", {31'b0, err_o}, {31'b0, e.err});
      end
    end
    if (dm_ack_o) begin
      if (dm_q.size() == 0) check("dm_ack_unexpected", {31'b0, dm_ack_o}, 32'd0);
      else begin
        e = dm_q.pop_front();
        check("dm_rdata", dm_rdata_o, e.data);
        check("dm_err", {31'b0, err_o}, {31'b0, e.err});
      end
    end
    if (err_o && !if_ack_o && !dm_ack_o) check("err_unexpected", {31'b0, err_o}, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    int lat, first_stb, dn, i_n, stb_cycles, ack_c;
    bit held_ok, d_seen, i_seen;
    logic exp_we;
    logic [3:0] exp_sel;
    logic [31:0] exp_wdata;
    string order;

    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_002C, 32'h0, 0, 2};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 0, 2};
    vecs[2] = '{1'b0, 1'b0, 4'hF, 32'h0000_0048, 32'h0, 1, 3};
    vecs[3] = '{1'b1, 1'b1, 4'h3, 32'h0000_0040, 32'hDEAD_BEEF, 2, 4};
    vecs[4] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 3, 5};
    vecs[5] = '{1'b0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 0, 2};
    vecs[6] = '{1'b1, 1'b1, 4'hC, 32'h0000_0044, 32'h1234_5678, 0, 2};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_stb", {31'b0, mem_stb_o}, 32'd0);
    check("rst_cyc", {31'b0, mem_cyc_o}, 32'd0);
    check("rst_if_ack", {31'b0, if_ack_o}, 32'd0);
    check("rst_dm_ack", {31'b0, dm_ack_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_if_rdata", if_rdata_o, 32'd0);
    check("rst_dm_rdata", dm_rdata_o, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    rst = 1'b1;

    // Table of single accesses
    for (int v = 0; v < 7; v++) begin
      t = vecs[v];
      lat = -1;
      first_stb = -1;
      held_ok = 1'b1;
      exp_we = t.dm ? t.we : 1'b0;
      exp_sel = t.dm ? t.sel : 4'hF;
      exp_wdata = t.dm ? t.wdata : 32'h0;
      wait_states = t.waits;
      @(posedge clk); #1;
      if (t.dm) begin
        dm_req_i = 1'b1; dm_we_i = t.we; dm_sel_i = t.sel;
        dm_addr_i = t.addr; dm_wdata_i = t.wdata;
        dm_q.push_back('{data: mem_word(t.addr), err: 1'b0});
      end else begin
        if_req_i = 1'b1; if_addr_i = t.addr;
        if_q.push_back('{data: mem_word(t.addr), err: 1'b0});
      end
      for (int c = 0; c < 40 && lat < 0; c++) begin
        @(negedge clk);
        if (c == 0) check($sformatf("v%0d_stall_req", v), {31'b0, stallreq_o}, 32'd1);
        if (mem_stb_o) begin
          if (first_stb < 0) first_stb = c;
          if (mem_we_o !== exp_we || mem_sel_o !== exp_sel || mem_addr_o !== t.addr ||
              mem_wdata_o !== exp_wdata) held_ok = 1'b0;
        end
        if ((t.dm ? dm_ack_o : if_ack_o) === 1'b1) begin
          lat = c;
          check($sformatf("v%0d_stall_ack", v), {31'b0, stallreq_o}, 32'd0);
        end
      end
      check($sformatf("v%0d_latency", v), lat, t.exp_lat);
      check($sformatf("v%0d_first_stb", v), first_stb, 32'd1);
      check($sformatf("v%0d_bus_held", v), {31'b0, held_ok}, 32'd1);
      if (t.dm && t.we) begin
        check($sformatf("v%0d_wr_addr", v), wr_addr, t.addr);
        check($sformatf("v%0d_wr_data", v), wr_data, t.wdata);
        check($sformatf("v%0d_wr_sel", v), {28'b0, wr_sel}, {28'b0, t.sel});
      end
      @(posedge clk); #1;
      if_req_i = 1'b0;
      dm_req_i = 1'b0;
      @(posedge clk); #1;
    end

    // Simultaneous requests: data first, fetch back-to-back
    wait_states = 0;
    @(posedge clk); #1;
    if_req_i = 1'b1; if_addr_i = 32'h30;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h100; dm_wdata_i = '0;
    dm_q.push_back('{data: mem_word(32'h100), err: 1'b0});
    if_q.push_back('{data: mem_word(32'h30), err: 1'b0});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("t2_stb_c%0d", c), {31'b0, mem_stb_o}, {31'b0, t2_stb[c]});
      check($sformatf("t2_dm_ack_c%0d", c), {31'b0, dm_ack_o}, {31'b0, t2_dack[c]});
      check($sformatf("t2_if_ack_c%0d", c), {31'b0, if_ack_o}, {31'b0, t2_iack[c]});
      check($sformatf("t2_stall_c%0d", c), {31'b0, stallreq_o}, {31'b0, t2_stl[c]});
      if (c == 1) check("t2_addr_c1", mem_addr_o, 32'h100);
      if (c == 2) check("t2_addr_c2", mem_addr_o, 32'h30);
      @(posedge clk); #1;
      if (c == 2) dm_req_i = 1'b0;
      if (c == 3) if_req_i = 1'b0;
    end

    // Continuous requests from both ports with 2 wait states
    wait_states = 2;
    order = "";
    dn = 0;
    i_n = 0;
    @(posedge clk); #1;
    dm_req_i = 1'b1; dm_addr_i = 32'h300;
    dm_q.push_back('{data: mem_word(32'h300), err: 1'b0});
    if_req_i = 1'b1; if_addr_i = 32'h500;
    if_q.push_back('{data: mem_word(32'h500), err: 1'b0});
    for (int c = 0; c < 80 && (dn < 3 || i_n < 3); c++) begin
      @(negedge clk);
      d_seen = dm_ack_o;
      i_seen = if_ack_o;
      if (d_seen) begin order = {order, "D"}; dn++; end
      if (i_seen) begin order = {order, "I"}; i_n++; end
      @(posedge clk); #1;
      if (d_seen) begin
        if (dn < 3) begin
          dm_addr_i = 32'h300 + 32'(4 * dn);
          dm_q.push_back('{data: mem_word(dm_addr_i), err: 1'b0});
        end else dm_req_i = 1'b0;
      end
      if (i_seen) begin
        if (i_n < 3) begin
          if_addr_i = 32'h500 + 32'(4 * i_n);
          if_q.push_back('{data: mem_word(if_addr_i), err: 1'b0});
        end else if_req_i = 1'b0;
      end
    end
    dm_req_i = 1'b0;
    if_req_i = 1'b0;
    checks++;
    if (order != "DIDIDI") begin
      errors++;
      $display("FAIL t3_order: got %s, want DIDIDI", order);
    end
    @(posedge clk); #1;

    // Flush during a 3-wait fetch, then fetch 0x48
    wait_states = 3;
    @(posedge clk); #1;
    if_req_i = 1'b1; if_addr_i = 32'h60;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("t5_stb_c%0d", c), {31'b0, mem_stb_o}, {31'b0, t5_stb[c]});
      check($sformatf("t5_if_ack_c%0d", c), {31'b0, if_ack_o}, {31'b0, t5_iack[c]});
      if (c == 4) check("t5_drain_addr", mem_addr_o, 32'h60);
      if (c == 6) check("t5_next_addr", mem_addr_o, 32'h48);
      @(posedge clk); #1;
      if (c == 1) begin flush_i = 1'b1; if_req_i = 1'b0; end
      if (c == 2) begin
        flush_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h48;
        if_q.push_back('{data: mem_word(32'h48), err: 1'b0});
      end
      if (c == 4) wait_states = 0;
      if (c == 7) if_req_i = 1'b0;
    end

    // Memory never acks: timeout
    mem_noack = 1'b1;
    @(posedge clk); #1;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h700;
    dm_q.push_back('{data: 32'h0, err: 1'b1});
    stb_cycles = 0;
    ack_c = -1;
    for (int c = 0; c < 40 && ack_c < 0; c++) begin
      @(negedge clk);
      if (mem_stb_o) stb_cycles++;
      if (dm_ack_o) begin
        ack_c = c;
        check("t6_stb_at_ack", {31'b0, mem_stb_o}, 32'd0);
      end
    end
    check("t6_stb_cycles", stb_cycles, 32'd15);
    check("t6_ack_cycle", ack_c, 32'd16);
    @(posedge clk); #1;
    dm_req_i = 1'b0;

    // Async reset in the middle of a stalled fetch
    @(posedge clk); #1;
    if_req_i = 1'b1; if_addr_i = 32'h80;
    @(negedge clk);
    @(negedge clk);
    check("t6_busy_before_rst", {31'b0, mem_cyc_o}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_cyc_after_rst", {31'b0, mem_cyc_o}, 32'd0);
    check("t6_stb_after_rst", {31'b0, mem_stb_o}, 32'd0);
    if_req_i = 1'b0;
    mem_noack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t6_post_rst_ack_c%0d", c), {31'b0, if_ack_o}, 32'd0);
      check($sformatf("t6_post_rst_err_c%0d", c), {31'b0, err_o}, 32'd0);
    end

    check("if_queue_drained", if_q.size(), 32'd0);
    check("dm_queue_drained", dm_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
